commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- Retire stage that drives the consumer side of the reorder-buffer commit interface.
- Each cycle it inspects the ROB head and decides whether to retire it by asserting commit_ack.
- On retirement it performs the architectural side effects: register-file write, store issue to the memory controller, branch-predictor update, and a global flush/redirect on misprediction.
- Sits between the reorder buffer, the register file/rename table, the data-memory write port and the fetch unit.

Parameters:
ROB_ID_WIDTH, 3, width of ROB index (ROB of 8 entries)
OP_WIDTH, 8, width of AluOp encoding
XLEN, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid  in  1  ROB head present and ready
commit_id  in  ROB_ID_WIDTH  head ROB index
commit_op  in  OP_WIDTH  head op
commit_rd  in  5  head destination register
commit_value  in  XLEN  result value / store data
commit_pc  in  XLEN  head instruction PC
commit_addr  in  XLEN  store address or actual branch/jump target
commit_pred  in  1  predicted taken
commit_outcome  in  1  actual taken
commit_pred_target  in  XLEN  predicted target
commit_ack  out  1  retire head this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  5  write register
rf_wdata  out  XLEN  write data
rf_wrob  out  ROB_ID_WIDTH  retiring ROB id, used by rename table to clear matching tag
mem_wr_valid  out  1  store request
mem_wr_addr  out  XLEN  store address
mem_wr_data  out  XLEN  store data
mem_wr_size  out  2  0=byte, 1=half, 2=word
mem_wr_done  in  1  store completed (1-cycle pulse)
flush  out  1  global pipeline flush
redirect_valid  out  1  fetch redirect
redirect_pc  out  XLEN  redirect target
bp_update_valid  out  1  predictor update
bp_update_pc  out  XLEN  branch PC
bp_update_taken  out  1  actual outcome
retired_cnt  out  32  instructions retired
mispredict_cnt  out  32  mispredictions

Behaviour:
- Op classes come from the defines.v constants: STORE (SB/SH/SW), BRANCH (BEQ..BGEU), JAL, JALR, OTHER.
- States: RUN and STORE_WAIT. Reset goes to RUN.
- Reset values: all registered outputs 0, both counters 0. Combinational outputs are 0 whenever rst=1.
- RUN, commit_valid=0: all pulse outputs 0.
- RUN, head is OTHER/JAL/JALR/BRANCH:
  - commit_ack=1 combinationally in the same cycle (zero-latency retire).
  - rf_we=1 iff class ∈ {OTHER, JAL, JALR} and commit_rd≠0. rf_waddr=commit_rd, rf_wdata=commit_value, rf_wrob=commit_id.
- RUN, head is STORE:
  - commit_ack=0. On the next edge, register mem_wr_valid=1, addr=commit_addr, data=commit_value, size from op; go to STORE_WAIT.
- STORE_WAIT:
  - mem_wr_valid and its payload stay stable until the cycle mem_wr_done=1.
  - In that cycle: commit_ack=1, rf_we=0. Next edge: mem_wr_valid=0, return to RUN.
  - Throughput: minimum 2 cycles per store.
- BRANCH:
  - bp_update_valid=1, bp_update_pc=commit_pc, bp_update_taken=commit_outcome.
  - Mispredict if commit_pred≠commit_outcome, or (commit_outcome=1 and commit_pred_target≠commit_addr).
  - Redirect target = commit_outcome ? commit_addr : commit_pc+4 (mod 2^XLEN).
- JALR: mispredict if commit_pred=0 or commit_pred_target≠commit_addr; target = commit_addr.
- JAL: never mispredicts.
- On mispredict:
  - flush=1, redirect_valid=1, redirect_pc=target, in the same cycle as commit_ack.
  - The rf write of the jump's link value still occurs that cycle.
  - flush is a single-cycle pulse; no state change.
- Counters:
  - retired_cnt += 1 on every commit_ack.
  - mispredict_cnt += 1 on every flush.
  - Both wrap at 2^32.
- No external flush input: this block is the sole flush source. An in-flight store is never cancelled.
- rst in STORE_WAIT: mem_wr_valid drops at the reset edge and the FSM returns to RUN. A late mem_wr_done in RUN is ignored.
- commit_valid falling while in STORE_WAIT (must not happen): hold the request, ack nothing until both mem_wr_done=1 and commit_valid=1.

Test Plan:
- ADD rd=5, value=0x1234, commit_valid 1 cycle -> same cycle commit_ack=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234; retired_cnt=1.
- ADDI rd=0 -> commit_ack=1, rf_we=0.
- SW addr=0x100, data=0xDEADBEEF, mem_wr_done 3 cycles after request -> mem_wr_valid held 3 cycles with size=2; commit_ack only in the done cycle; next cycle mem_wr_valid=0.
- BEQ pc=0x40, pred=1, outcome=0 -> flush=1, redirect_pc=0x44, bp_update_taken=0, mispredict_cnt=1. Same case with pred=1, outcome=1, matching target -> no flush.
- JALR pc=0x80, rd=1, value=0x84, pred_target=0x200, addr=0x300 -> rf_we to x1 = 0x84, flush=1, redirect_pc=0x300.
- rst asserted during STORE_WAIT, then mem_wr_done pulse -> mem_wr_valid=0 after reset edge, no commit_ack, counters 0.

Source files
------------

// File: rtl/commit_unit_if.sv
// Commit-side bundle of the retire stage: ROB head in, architectural side
// effects out, plus the data-memory write port and retire statistics.
//   slave  : used by commit_unit (consumes the ROB head, drives side effects)
//   master : used by the surrounding pipeline / bench
interface commit_unit_if #(
    parameter int unsigned ROB_ID_WIDTH = 3,
    parameter int unsigned OP_WIDTH     = 8,
    parameter int unsigned XLEN         = 32
);
    // ROB head
    logic                    commit_valid;
    logic [ROB_ID_WIDTH-1:0] commit_id;
    logic [OP_WIDTH-1:0]     commit_op;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_value;
    logic [XLEN-1:0]         commit_pc;
    logic [XLEN-1:0]         commit_addr;
    logic                    commit_pred;
    logic                    commit_outcome;
    logic [XLEN-1:0]         commit_pred_target;
    logic                    commit_ack;
    // register file / rename table
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic [ROB_ID_WIDTH-1:0] rf_wrob;
    // data-memory write port
    logic                    mem_wr_valid;
    logic [XLEN-1:0]         mem_wr_addr;
    logic [XLEN-1:0]         mem_wr_data;
    logic [1:0]              mem_wr_size;
    logic                    mem_wr_done;
    // fetch / predictor
    logic                    flush;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic                    bp_update_valid;
    logic [XLEN-1:0]         bp_update_pc;
    logic                    bp_update_taken;
    // statistics
    logic [31:0]             retired_cnt;
    logic [31:0]             mispredict_cnt;

    modport slave (
        input  commit_valid, commit_id, commit_op, commit_rd, commit_value,
               commit_pc, commit_addr, commit_pred, commit_outcome,
               commit_pred_target, mem_wr_done,
        output commit_ack, rf_we, rf_waddr, rf_wdata, rf_wrob,
               mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_size,
               flush, redirect_valid, redirect_pc,
               bp_update_valid, bp_update_pc, bp_update_taken,
               retired_cnt, mispredict_cnt
    );

    modport master (
        output commit_valid, commit_id, commit_op, commit_rd, commit_value,
               commit_pc, commit_addr, commit_pred, commit_outcome,
               commit_pred_target, mem_wr_done,
        input  commit_ack, rf_we, rf_waddr, rf_wdata, rf_wrob,
               mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_size,
               flush, redirect_valid, redirect_pc,
               bp_update_valid, bp_update_pc, bp_update_taken,
               retired_cnt, mispredict_cnt
    );
endinterface

// File: rtl/commit_unit.sv
// Retire stage. Inspects the ROB head each cycle and retires it via
// commit_ack, performing the register write, store issue, predictor update
// and flush/redirect on mispredict.
// Ports: clk, rst (synchronous, active-high), cif (commit_unit_if.slave).
// commit_ack, rf_*, flush, redirect_*, bp_update_* are combinational and
// forced to 0 during reset; mem_wr_* and the counters are registered.
// AluOp encodings (mirror of defines.v):
//   SB=0x20 SH=0x21 SW=0x22, BEQ..BGEU=0x30..0x35, JAL=0x40, JALR=0x41,
//   anything else is an ordinary register-writing op.
module commit_unit #(
    parameter int unsigned ROB_ID_WIDTH = 3,
    parameter int unsigned OP_WIDTH     = 8,
    parameter int unsigned XLEN         = 32
) (
    input  logic         clk,
    input  logic         rst,
    commit_unit_if.slave cif
);
    localparam logic [OP_WIDTH-1:0] OP_SB   = OP_WIDTH'(8'h20);
    localparam logic [OP_WIDTH-1:0] OP_SH   = OP_WIDTH'(8'h21);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(8'h22);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(8'h30);
    localparam logic [OP_WIDTH-1:0] OP_BGEU = OP_WIDTH'(8'h35);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(8'h40);
    localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(8'h41);

    typedef enum logic {RUN, STORE_WAIT} state_t;

    state_t          state_q, state_d;
    logic            wr_valid_q, wr_valid_d;
    logic [XLEN-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [1:0]      wr_size_q, wr_size_d;
    logic [31:0]     retired_q, mispred_q;

    logic            ack, rf_we, flush, redirect_valid, bp_valid, bp_taken;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata, redirect_pc, bp_pc;
    logic [ROB_ID_WIDTH-1:0] rf_wrob;

    // op class decode
    logic is_store, is_branch, is_jal, is_jalr;
    logic [1:0] store_size;
    always_comb begin
        is_store   = (cif.commit_op == OP_SB) || (cif.commit_op == OP_SH) ||
                     (cif.commit_op == OP_SW);
        is_branch  = (cif.commit_op >= OP_BEQ) && (cif.commit_op <= OP_BGEU);
        is_jal     = (cif.commit_op == OP_JAL);
        is_jalr    = (cif.commit_op == OP_JALR);
        store_size = (cif.commit_op == OP_SB) ? 2'd0 :
                     (cif.commit_op == OP_SH) ? 2'd1 : 2'd2;
    end

    // misprediction detection and redirect target
    logic            mispredict;
    logic [XLEN-1:0] target;
    always_comb begin
        mispredict = 1'b0;
        target     = cif.commit_addr;
        if (is_branch) begin
            mispredict = (cif.commit_pred != cif.commit_outcome) ||
                         (cif.commit_outcome && (cif.commit_pred_target != cif.commit_addr));
            target     = cif.commit_outcome ? cif.commit_addr
                                            : XLEN'(cif.commit_pc + XLEN'(4));
        end else if (is_jalr) begin
            mispredict = !cif.commit_pred || (cif.commit_pred_target != cif.commit_addr);
        end
    end

    // next-state and retire outputs
    always_comb begin
        state_d        = state_q;
        wr_valid_d     = wr_valid_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        wr_size_d      = wr_size_q;
        ack            = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        rf_wrob        = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bp_valid       = 1'b0;
        bp_pc          = '0;
        bp_taken       = 1'b0;
        if (!rst) begin
            rf_waddr = cif.commit_rd;
            rf_wdata = cif.commit_value;
            rf_wrob  = cif.commit_id;
            bp_pc    = cif.commit_pc;
            bp_taken = cif.commit_outcome;
            unique case (state_q)
                RUN: begin
                    if (cif.commit_valid) begin
                        if (is_store) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cif.commit_addr;
                            wr_data_d  = cif.commit_value;
                            wr_size_d  = store_size;
                            state_d    = STORE_WAIT;
                        end else begin
                            ack      = 1'b1;
                            rf_we    = !is_branch && (cif.commit_rd != 5'd0);
                            bp_valid = is_branch;
                            if (mispredict) begin
                                flush          = 1'b1;
                                redirect_valid = 1'b1;
                                redirect_pc    = target;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    // store retires only when the write has landed and the head is still presented
                    if (cif.mem_wr_done && cif.commit_valid) begin
                        ack        = 1'b1;
                        wr_valid_d = 1'b0;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // state, store request and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_size_q  <= 2'd0;
            retired_q  <= 32'd0;
            mispred_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_size_q  <= wr_size_d;
            if (ack)   retired_q <= retired_q + 32'd1;
            if (flush) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign cif.commit_ack      = ack;
    assign cif.rf_we           = rf_we;
    assign cif.rf_waddr        = rf_waddr;
    assign cif.rf_wdata        = rf_wdata;
    assign cif.rf_wrob         = rf_wrob;
    assign cif.mem_wr_valid    = wr_valid_q;
    assign cif.mem_wr_addr     = wr_addr_q;
    assign cif.mem_wr_data     = wr_data_q;
    assign cif.mem_wr_size     = wr_size_q;
    assign cif.flush           = flush;
    assign cif.redirect_valid  = redirect_valid;
    assign cif.redirect_pc     = redirect_pc;
    assign cif.bp_update_valid = bp_valid;
    assign cif.bp_update_pc    = bp_pc;
    assign cif.bp_update_taken = bp_taken;
    assign cif.retired_cnt     = retired_q;
    assign cif.mispredict_cnt  = mispred_q;
endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit.
module tb_commit_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_unit_if #(.ROB_ID_WIDTH(3), .OP_WIDTH(8), .XLEN(32)) cif ();
    commit_unit #(.ROB_ID_WIDTH(3), .OP_WIDTH(8), .XLEN(32)) dut (.clk(clk), .rst(rst), .cif(cif));

    localparam logic [7:0] ADD = 8'h00, ADDI = 8'h10, SB = 8'h20, SH = 8'h21, SW = 8'h22;
    localparam logic [7:0] BEQ = 8'h30, BNE = 8'h31, JAL = 8'h40, JALR = 8'h41;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic drive(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] value,
                         input logic [31:0] pc, input logic [31:0] addr, input logic pred,
                         input logic outcome, input logic [31:0] ptgt, input logic [2:0] id);
        cif.commit_valid = 1'b1; cif.commit_op = op; cif.commit_rd = rd;
        cif.commit_value = value; cif.commit_pc = pc; cif.commit_addr = addr;
        cif.commit_pred = pred; cif.commit_outcome = outcome;
        cif.commit_pred_target = ptgt; cif.commit_id = id;
    endtask

    task automatic idle();
        cif.commit_valid = 1'b0; cif.mem_wr_done = 1'b0; cif.commit_op = ADD;
        cif.commit_rd = 5'd0; cif.commit_value = 32'd0; cif.commit_pc = 32'd0;
        cif.commit_addr = 32'd0; cif.commit_pred = 1'b0; cif.commit_outcome = 1'b0;
        cif.commit_pred_target = 32'd0; cif.commit_id = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        @(negedge clk);
        drive(ADD, 5'd3, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd1);
        #1;
        n_checks++; if (cif.commit_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", cif.commit_ack); end
        n_checks++; if (cif.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %b want 0", cif.rf_we); end
        @(posedge clk); #1;
        n_checks++; if (cif.mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", cif.mem_wr_valid); end
        n_checks++; if (cif.retired_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_retired: got %0d want 0", cif.retired_cnt); end
        n_checks++; if (cif.mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mispred: got %0d want 0", cif.mispredict_cnt); end
        @(negedge clk); rst = 1'b0; idle();
        #1;
        n_checks++; if (cif.commit_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %b want 0", cif.commit_ack); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(ADD, 5'd5, 32'h1234, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 3'd2);
        #1;
        n_checks++; if (cif.commit_ack !== 1'b1) begin n_fail++; $display("FAIL alu_ack: got %b want 1", cif.commit_ack); end
        n_checks++; if (cif.rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_rf_we: got %b want 1", cif.rf_we); end
        n_checks++; if (cif.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_waddr: got %0d want 5", cif.rf_waddr); end
        n_checks++; if (cif.rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h want 00001234", cif.rf_wdata); end
        n_checks++; if (cif.rf_wrob !== 3'd2) begin n_fail++; $display("FAIL alu_wrob: got %0d want 2", cif.rf_wrob); end
        n_checks++; if (cif.bp_update_valid !== 1'b0 || cif.flush !== 1'b0) begin n_fail++; $display("FAIL alu_bp_flush: got %b%b want 00", cif.bp_update_valid, cif.flush); end
        @(posedge clk); #1;
        n_checks++; if (cif.retired_cnt !== 32'd1) begin n_fail++; $display("FAIL alu_retired: got %0d want 1", cif.retired_cnt); end
        @(negedge clk);
        drive(ADDI, 5'd0, 32'h99, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 3'd3);
        #1;
        n_checks++; if (cif.commit_ack !== 1'b1) begin n_fail++; $display("FAIL x0_ack: got %b want 1", cif.commit_ack); end
        n_checks++; if (cif.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_rf_we: got %b want 0", cif.rf_we); end
        @(posedge clk); #1;
        n_checks++; if (cif.retired_cnt !== 32'd2) begin n_fail++; $display("FAIL x0_retired: got %0d want 2", cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    task automatic test_store();
        @(negedge clk);
        drive(SW, 5'd7, 32'hDEADBEEF, 32'h20, 32'h100, 1'b0, 1'b0, 32'h0, 3'd4);
        #1;
        n_checks++; if (cif.commit_ack !== 1'b0) begin n_fail++; $display("FAIL st_issue_ack: got %b want 0", cif.commit_ack); end
        n_checks++; if (cif.mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL st_issue_valid: got %b want 0", cif.mem_wr_valid); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cif.mem_wr_done = (c == 3);
            #1;
            n_checks++; if (cif.mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid_c%0d: got %b want 1", c, cif.mem_wr_valid); end
            n_checks++; if (cif.mem_wr_addr !== 32'h100 || cif.mem_wr_data !== 32'hDEADBEEF || cif.mem_wr_size !== 2'd2) begin
                n_fail++; $display("FAIL st_payload_c%0d: got %h/%h/%0d want 00000100/deadbeef/2", c, cif.mem_wr_addr, cif.mem_wr_data, cif.mem_wr_size); end
            n_checks++; if (cif.commit_ack !== (c == 3)) begin n_fail++; $display("FAIL st_ack_c%0d: got %b want %b", c, cif.commit_ack, (c == 3)); end
            n_checks++; if (cif.rf_we !== 1'b0) begin n_fail++; $display("FAIL st_rf_we_c%0d: got %b want 0", c, cif.rf_we); end
        end
        @(posedge clk); #1;
        n_checks++; if (cif.mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL st_release: got %b want 0", cif.mem_wr_valid); end
        n_checks++; if (cif.retired_cnt !== 32'd3) begin n_fail++; $display("FAIL st_retired: got %0d want 3", cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    // head disappears while waiting: request held, nothing acked until both done and valid
    task automatic test_store_valid_drop();
        @(negedge clk);
        drive(SH, 5'd0, 32'h0000ABCD, 32'h24, 32'h202, 1'b0, 1'b0, 32'h0, 3'd5);
        @(negedge clk);
        cif.commit_valid = 1'b0; cif.mem_wr_done = 1'b1;
        #1;
        n_checks++; if (cif.commit_ack !== 1'b0) begin n_fail++; $display("FAIL drop_ack: got %b want 0", cif.commit_ack); end
        n_checks++; if (cif.mem_wr_size !== 2'd1) begin n_fail++; $display("FAIL drop_size: got %0d want 1", cif.mem_wr_size); end
        @(negedge clk);
        cif.commit_valid = 1'b1; cif.mem_wr_done = 1'b1;
        #1;
        n_checks++; if (cif.mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL drop_hold: got %b want 1", cif.mem_wr_valid); end
        n_checks++; if (cif.commit_ack !== 1'b1) begin n_fail++; $display("FAIL drop_late_ack: got %b want 1", cif.commit_ack); end
        @(posedge clk); #1;
        n_checks++; if (cif.retired_cnt !== 32'd4) begin n_fail++; $display("FAIL drop_retired: got %0d want 4", cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    // two stores with immediate completion: 2 cycles each
    task automatic test_back_to_back();
        @(negedge clk);
        drive(SB, 5'd0, 32'h11, 32'h30, 32'h300, 1'b0, 1'b0, 32'h0, 3'd6);
        @(negedge clk); cif.mem_wr_done = 1'b1; #1;
        n_checks++; if (cif.commit_ack !== 1'b1 || cif.mem_wr_size !== 2'd0) begin n_fail++; $display("FAIL b2b_first: got ack %b size %0d want 1/0", cif.commit_ack, cif.mem_wr_size); end
        @(negedge clk);
        drive(SW, 5'd0, 32'h22, 32'h34, 32'h304, 1'b0, 1'b0, 32'h0, 3'd7);
        cif.mem_wr_done = 1'b0; #1;
        n_checks++; if (cif.commit_ack !== 1'b0 || cif.mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ack %b valid %b want 0/0", cif.commit_ack, cif.mem_wr_valid); end
        @(negedge clk); cif.mem_wr_done = 1'b1; #1;
        n_checks++; if (cif.commit_ack !== 1'b1 || cif.mem_wr_data !== 32'h22) begin n_fail++; $display("FAIL b2b_second: got ack %b data %h want 1/00000022", cif.commit_ack, cif.mem_wr_data); end
        @(posedge clk); #1;
        n_checks++; if (cif.retired_cnt !== 32'd6) begin n_fail++; $display("FAIL b2b_retired: got %0d want 6", cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    task automatic test_branch();
        @(negedge clk);
        drive(BEQ, 5'd9, 32'h0, 32'h40, 32'h80, 1'b1, 1'b0, 32'h80, 3'd0);
        #1;
        n_checks++; if (cif.commit_ack !== 1'b1 || cif.rf_we !== 1'b0) begin n_fail++; $display("FAIL br_ack_we: got %b%b want 10", cif.commit_ack, cif.rf_we); end
        n_checks++; if (cif.flush !== 1'b1 || cif.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b%b want 11", cif.flush, cif.redirect_valid); end
        n_checks++; if (cif.redirect_pc !== 32'h44) begin n_fail++; $display("FAIL br_redirect: got %h want 00000044", cif.redirect_pc); end
        n_checks++; if (cif.bp_update_valid !== 1'b1 || cif.bp_update_pc !== 32'h40 || cif.bp_update_taken !== 1'b0) begin
            n_fail++; $display("FAIL br_bp: got %b/%h/%b want 1/00000040/0", cif.bp_update_valid, cif.bp_update_pc, cif.bp_update_taken); end
        @(posedge clk); #1;
        n_checks++; if (cif.mispredict_cnt !== 32'd1) begin n_fail++; $display("FAIL br_mispred: got %0d want 1", cif.mispredict_cnt); end
        @(negedge clk);
        drive(BEQ, 5'd0, 32'h0, 32'h40, 32'h80, 1'b1, 1'b1, 32'h80, 3'd1);
        #1;
        n_checks++; if (cif.flush !== 1'b0 || cif.bp_update_taken !== 1'b1 || cif.commit_ack !== 1'b1) begin
            n_fail++; $display("FAIL br_correct: got flush %b taken %b ack %b want 0/1/1", cif.flush, cif.bp_update_taken, cif.commit_ack); end
        @(negedge clk);
        drive(BNE, 5'd0, 32'h0, 32'h50, 32'h90, 1'b1, 1'b1, 32'h94, 3'd2);
        #1;
        n_checks++; if (cif.flush !== 1'b1 || cif.redirect_pc !== 32'h90) begin n_fail++; $display("FAIL br_wrong_tgt: got %b/%h want 1/00000090", cif.flush, cif.redirect_pc); end
        @(negedge clk);
        drive(BEQ, 5'd0, 32'h0, 32'hFFFFFFFC, 32'h10, 1'b1, 1'b0, 32'h10, 3'd3);
        #1;
        n_checks++; if (cif.flush !== 1'b1 || cif.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL br_wrap: got %b/%h want 1/00000000", cif.flush, cif.redirect_pc); end
        @(posedge clk); #1;
        n_checks++; if (cif.mispredict_cnt !== 32'd3 || cif.retired_cnt !== 32'd10) begin
            n_fail++; $display("FAIL br_counts: got %0d/%0d want 3/10", cif.mispredict_cnt, cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    task automatic test_jumps();
        @(negedge clk);
        drive(JALR, 5'd1, 32'h84, 32'h80, 32'h300, 1'b1, 1'b1, 32'h200, 3'd4);
        #1;
        n_checks++; if (cif.rf_we !== 1'b1 || cif.rf_waddr !== 5'd1 || cif.rf_wdata !== 32'h84) begin
            n_fail++; $display("FAIL jalr_link: got %b/%0d/%h want 1/1/00000084", cif.rf_we, cif.rf_waddr, cif.rf_wdata); end
        n_checks++; if (cif.flush !== 1'b1 || cif.redirect_pc !== 32'h300 || cif.bp_update_valid !== 1'b0) begin
            n_fail++; $display("FAIL jalr_redirect: got %b/%h/%b want 1/00000300/0", cif.flush, cif.redirect_pc, cif.bp_update_valid); end
        @(negedge clk);
        drive(JALR, 5'd1, 32'h88, 32'h84, 32'h300, 1'b1, 1'b1, 32'h300, 3'd5);
        #1;
        n_checks++; if (cif.flush !== 1'b0 || cif.commit_ack !== 1'b1) begin n_fail++; $display("FAIL jalr_hit: got flush %b ack %b want 0/1", cif.flush, cif.commit_ack); end
        @(negedge clk);
        drive(JALR, 5'd2, 32'h8C, 32'h88, 32'h300, 1'b0, 1'b1, 32'h300, 3'd6);
        #1;
        n_checks++; if (cif.flush !== 1'b1) begin n_fail++; $display("FAIL jalr_notpred: got %b want 1", cif.flush); end
        @(negedge clk);
        drive(JAL, 5'd3, 32'h90, 32'h8C, 32'h400, 1'b0, 1'b1, 32'h0, 3'd7);
        #1;
        n_checks++; if (cif.flush !== 1'b0 || cif.rf_we !== 1'b1 || cif.rf_wrob !== 3'd7) begin
            n_fail++; $display("FAIL jal: got flush %b we %b rob %0d want 0/1/7", cif.flush, cif.rf_we, cif.rf_wrob); end
        @(posedge clk); #1;
        n_checks++; if (cif.mispredict_cnt !== 32'd5 || cif.retired_cnt !== 32'd14) begin
            n_fail++; $display("FAIL jmp_counts: got %0d/%0d want 5/14", cif.mispredict_cnt, cif.retired_cnt); end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_in_store();
        @(negedge clk);
        drive(SW, 5'd0, 32'hCAFE, 32'h60, 32'h500, 1'b0, 1'b0, 32'h0, 3'd1);
        @(negedge clk); #1;
        n_checks++; if (cif.mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL rs_pending: got %b want 1", cif.mem_wr_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (cif.mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL rs_drop: got %b want 0", cif.mem_wr_valid); end
        n_checks++; if (cif.retired_cnt !== 32'd0 || cif.mispredict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rs_counts: got %0d/%0d want 0/0", cif.retired_cnt, cif.mispredict_cnt); end
        @(negedge clk); rst = 1'b0; cif.commit_valid = 1'b0; cif.mem_wr_done = 1'b1; #1;
        n_checks++; if (cif.commit_ack !== 1'b0) begin n_fail++; $display("FAIL rs_late_done: got %b want 0", cif.commit_ack); end
        @(posedge clk); #1;
        n_checks++; if (cif.retired_cnt !== 32'd0 || cif.mem_wr_valid !== 1'b0) begin
            n_fail++; $display("FAIL rs_after: got %0d/%b want 0/0", cif.retired_cnt, cif.mem_wr_valid); end
        @(negedge clk); idle();
        drive(ADD, 5'd4, 32'h7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd2); #1;
        n_checks++; if (cif.commit_ack !== 1'b1) begin n_fail++; $display("FAIL rs_run_again: got %b want 1", cif.commit_ack); end
        @(negedge clk); idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_alu();
        test_store();
        test_store_valid_drop();
        test_back_to_back();
        test_branch();
        test_jumps();
        test_reset_in_store();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
